// File: rtl/mem_bus_pkg.sv
// Shared types for the CPU-side memory bus master.
// Holds FSM state encoding, response error codes and width defaults.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_LO,
    WAIT_LO,
    ISSUE_HI,
    WAIT_HI,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_BP      = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_t;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Per-beat not-ready wait counter for the memory bus master.
// expired flags the TIMEOUT-th consecutive not-ready cycle of a beat.
module bus_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_bus_master.sv
// CPU load/store master issuing one or two beats to a simple memory bus.
// Handles wait states, per-beat timeout and responder breakpoints.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic                req_wide,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [2*DATA_W-1:0] rsp_rdata,
  output logic [1:0]          rsp_err,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic                bus_we,
  output logic                bus_re,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ready,
  input  logic                bus_bp
);

  state_t state, stateNext;

  logic [ADDR_W-1:0]   addrQ;
  logic [2*DATA_W-1:0] wdataQ;
  logic                writeQ;
  logic                wideQ;
  logic [2*DATA_W-1:0] rdataQ;
  err_t                errQ;

  logic accept;
  logic issue;
  logic waitSt;
  logic hiBeat;
  logic expired;

  assign accept = (state == IDLE) && req_valid;
  assign issue  = (state == ISSUE_LO) || (state == ISSUE_HI);
  assign waitSt = (state == WAIT_LO) || (state == WAIT_HI);
  assign hiBeat = (state == ISSUE_HI) || (state == WAIT_HI);

  bus_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (!waitSt),
    .enable (waitSt && !bus_ready),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (req_valid) stateNext = ISSUE_LO;
      end
      ISSUE_LO: stateNext = WAIT_LO;
      WAIT_LO: begin
        if (expired) begin
          stateNext = RESP;
        end else if (bus_ready) begin
          // a breakpoint on the low beat suppresses the high beat
          stateNext = (wideQ && errQ == ERR_OK) ? ISSUE_HI : RESP;
        end
      end
      ISSUE_HI: stateNext = WAIT_HI;
      WAIT_HI: begin
        if (expired || bus_ready) stateNext = RESP;
      end
      RESP: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addrQ  <= '0;
      wdataQ <= '0;
      writeQ <= 1'b0;
      wideQ  <= 1'b0;
      rdataQ <= '0;
      errQ   <= ERR_OK;
    end else begin
      if (accept) begin
        addrQ  <= req_addr;
        wdataQ <= req_wdata;
        writeQ <= req_write;
        wideQ  <= req_wide;
        rdataQ <= '0;
        errQ   <= ERR_OK;
      end
      if (issue && bus_bp) errQ <= ERR_BP;
      if (waitSt && expired) begin
        errQ <= ERR_TIMEOUT;
      end else if (waitSt && bus_ready && !writeQ) begin
        if (hiBeat) rdataQ[DATA_W +: DATA_W] <= bus_rdata;
        else        rdataQ[0 +: DATA_W]      <= bus_rdata;
      end
    end
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_rdata = rdataQ;
    rsp_err   = errQ;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_re    = 1'b0;
    bus_we    = issue && writeQ;
    if (issue || waitSt) begin
      bus_addr  = hiBeat ? addrQ + ADDR_W'(1) : addrQ;
      bus_wdata = hiBeat ? wdataQ[DATA_W +: DATA_W] : wdataQ[0 +: DATA_W];
      bus_re    = !writeQ;
    end
  end

endmodule

// File: doc/mem_bus_master.md
MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning bus address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning bus data width (one beat).
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning max consecutive not-ready wait cycles per beat.
REQ-004 SHALL use a single clock and an asynchronous, active-low reset, with ports clk and rst.
REQ-005 SHALL have port clk  in  1  the only clock; all state on rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port req_valid  in  1  CPU access request.
REQ-008 SHALL have port req_ready  out  1  request accepted when req_valid & req_ready.
REQ-009 SHALL have port req_write  in  1  1 = store, 0 = load.
REQ-010 SHALL have port req_wide  in  1  1 = 32-bit access (two beats), 0 = one beat.
REQ-011 SHALL have port req_addr  in  ADDR_W  word address of the low half.
REQ-012 SHALL have port req_wdata  in  2*DATA_W  store data, [15:0] low beat, [31:16] high beat.
REQ-013 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-014 SHALL have port rsp_rdata  out  2*DATA_W  load data, upper half zero when narrow.
REQ-015 SHALL have port rsp_err  out  2  00 ok, 01 breakpoint, 10 timeout.
REQ-016 SHALL have port bus_addr  out  ADDR_W  address to the memory responder.
REQ-017 SHALL have port bus_wdata  out  DATA_W  write data.
REQ-018 SHALL have port bus_we  out  1  write strobe.
REQ-019 SHALL have port bus_re  out  1  read strobe.
REQ-020 SHALL have port bus_rdata  in  DATA_W  responder read data, valid one cycle after address.
REQ-021 SHALL have port bus_ready  in  1  responder ready.
REQ-022 SHALL have port bus_bp  in  1  responder breakpoint hit, combinational from the current strobe.

Function
REQ-023 SHALL implement FSM states IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, RESP.
REQ-024 SHALL assert req_ready only in IDLE; acceptance latches addr, wdata, write and wide, then moves to ISSUE_LO.
REQ-025 SHALL, in ISSUE_x, drive bus_addr = beat address, bus_re = !write, bus_we = write, bus_wdata = beat data.
REQ-026 SHALL assert bus_we for exactly one cycle per store beat (the ISSUE cycle only).
REQ-027 SHALL hold bus_addr and bus_re through WAIT_x, and SHALL capture bus_rdata in the first WAIT_x cycle with bus_ready high.
REQ-028 SHALL stay in WAIT_x while bus_ready is low, counting cycles; when the count reaches TIMEOUT, SHALL abort to RESP with rsp_err = 10.
REQ-029 SHALL sample bus_bp in ISSUE_x; if high, SHALL abort to RESP with rsp_err = 01 after the beat completes, and SHALL NOT issue a high beat.
REQ-030 SHALL use beat address req_addr + 1 for the high beat, wrapping modulo 2^ADDR_W (FFFFFFFF -> 00000000).
REQ-031 SHALL go WAIT_LO -> ISSUE_HI when wide, otherwise -> RESP; WAIT_HI -> RESP.
REQ-032 SHALL pulse rsp_valid for one cycle in RESP, then return to IDLE; there is no response backpressure.
REQ-033 SHALL, with zero wait states, give latency from the accept edge to rsp_valid of 3 cycles narrow and 5 cycles wide; minimum issue interval is 4 and 6 cycles.
REQ-034 SHALL return zero for unreceived halves on error; rsp_rdata and rsp_err are valid only while rsp_valid is high.
REQ-035 SHALL drive bus_addr = 0, bus_wdata = 0, bus_we = 0 and bus_re = 0 outside the ISSUE/WAIT states.
REQ-036 SHALL NOT cancel a committed store beat when a breakpoint is hit on it.

Reset
REQ-037 SHALL, on rst low, asynchronously force IDLE with req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 00, all bus outputs 0 and the wait counter 0.
REQ-038 SHALL, when reset occurs mid-access, abandon the access with no response; the bus is idle in the first cycle of reset.

Structure
REQ-039 SHALL place the FSM state enum, rsp_err codes, and ADDR_W/DATA_W defaults in the shared package mem_bus_pkg.
REQ-040 SHALL implement the per-beat wait counter as sub-module bus_timeout_ctr (inputs clear/enable; output expired at TIMEOUT).

Verification
REQ-041 SHALL verify narrow load of addr D0000010 with responder data 1234 -> rsp_rdata 00001234, err 00, rsp_valid 3 cycles after accept.
REQ-042 SHALL verify wide store of AABBCCDD to 10000000 -> beat 1 writes CCDD @10000000 and beat 2 writes AABB @10000001, one bus_we cycle each, rsp at +5.
REQ-043 SHALL verify wide load at FFFFFFFF -> high beat address 00000000, both halves assembled.
REQ-044 SHALL verify bus_ready held low 300 cycles on a load with TIMEOUT 255 -> rsp_err 10 after 255 wait cycles, rdata 0.
REQ-045 SHALL verify bus_bp high on the low beat of a wide store -> low beat written, no high beat, rsp_err 01.
REQ-046 SHALL verify rst pulsed low during WAIT_HI -> bus idle immediately, no rsp_valid, req_ready 1 after release.
